// File: rtl/pattern_compare.sv
`default_nettype none
// ============================================================================
//  Module      : pattern_compare
//  Description : Search engine for the pattern matching block. While the
//                control FSM holds inc_flag high, it scans pattern RAM from
//                address 0 upward. Each masked read word is compared with a
//                pattern captured at search start. done_flag is raised on the
//                first (lowest) hit, or after the last word misses.
//  Ports       : clock, reset (async, active high)
//                inc_flag            - search enable / release / abort
//                pattern, pattern_mask - search key, sampled at start
//                mem_data            - RAM read data (1-cycle latency)
//                mem_rd, mem_addr    - RAM read strobe and address
//                done_flag, match_address, match_found - search result
//  Revision    : 1.0 - initial release
// ============================================================================
module pattern_compare #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 512
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              inc_flag,
    input  logic [DATA_W-1:0] pattern,
    input  logic [DATA_W-1:0] pattern_mask,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              done_flag,
    output logic [ADDR_W-1:0] match_address,
    output logic              match_found
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_SCAN = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [DATA_W-1:0] r_pattern;
    logic [DATA_W-1:0] r_mask;
    logic [ADDR_W-1:0] r_addr_d1;
    logic              r_valid_d1;
    logic              r_mem_rd;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_done;
    logic [ADDR_W-1:0] r_match_address;
    logic              r_match_found;
    logic              w_cmp;
    logic              w_hit;
    logic              w_miss;

    // The data word returned this cycle belongs to the read issued one cycle
    // earlier; r_valid_d1/r_addr_d1 identify it.
    always_comb begin
        w_cmp       = (((mem_data ^ r_pattern) & r_mask) == '0);
        w_hit       = r_valid_d1 && w_cmp;
        w_miss      = r_valid_d1 && !w_cmp && (r_addr_d1 == c_LAST_ADDR);
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (inc_flag) w_state_nxt = c_ST_SCAN;
            c_ST_SCAN: begin
                if (!inc_flag)            w_state_nxt = c_ST_IDLE;
                else if (w_hit || w_miss) w_state_nxt = c_ST_DONE;
            end
            c_ST_DONE: if (!inc_flag) w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state         <= c_ST_IDLE;
            r_pattern       <= '0;
            r_mask          <= '0;
            r_addr_d1       <= '0;
            r_valid_d1      <= 1'b0;
            r_mem_rd        <= 1'b0;
            r_mem_addr      <= '0;
            r_done          <= 1'b0;
            r_match_address <= '0;
            r_match_found   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                c_ST_IDLE: begin
                    r_mem_rd   <= 1'b0;
                    r_valid_d1 <= 1'b0;
                    r_done     <= 1'b0;
                    if (inc_flag) begin
                        r_pattern       <= pattern;
                        r_mask          <= pattern_mask;
                        r_mem_addr      <= '0;
                        r_mem_rd        <= 1'b1;
                        r_match_found   <= 1'b0;
                        r_match_address <= '0;
                    end
                end
                c_ST_SCAN: begin
                    if (!inc_flag) begin
                        // Abort: drop the in-flight read, no result.
                        r_mem_rd   <= 1'b0;
                        r_valid_d1 <= 1'b0;
                    end else if (w_hit) begin
                        // Any read issued this cycle is simply discarded.
                        r_match_address <= r_addr_d1;
                        r_match_found   <= 1'b1;
                        r_done          <= 1'b1;
                        r_mem_rd        <= 1'b0;
                        r_valid_d1      <= 1'b0;
                    end else if (w_miss) begin
                        r_match_address <= '1;
                        r_match_found   <= 1'b0;
                        r_done          <= 1'b1;
                        r_mem_rd        <= 1'b0;
                        r_valid_d1      <= 1'b0;
                    end else begin
                        r_valid_d1 <= r_mem_rd;
                        r_addr_d1  <= r_mem_addr;
                        if (r_mem_rd) begin
                            // Stop issuing after the last word; address holds.
                            if (r_mem_addr == c_LAST_ADDR) r_mem_rd <= 1'b0;
                            else r_mem_addr <= r_mem_addr + 1'b1;
                        end
                    end
                end
                c_ST_DONE: begin
                    r_mem_rd   <= 1'b0;
                    r_valid_d1 <= 1'b0;
                    if (!inc_flag) r_done <= 1'b0;
                end
                default: begin
                    r_mem_rd   <= 1'b0;
                    r_valid_d1 <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

    assign mem_rd        = r_mem_rd;
    assign mem_addr      = r_mem_addr;
    assign done_flag     = r_done;
    assign match_address = r_match_address;
    assign match_found   = r_match_found;

endmodule
`default_nettype wire

// File: tb/tb_pattern_compare.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pattern_compare
//  Description : Self-checking bench for pattern_compare. A behavioural RAM
//                model answers reads; expected results come from a linear
//                search over the RAM contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_compare;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 512;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              inc_flag = 1'b0;
    logic [DATA_W-1:0] pattern = '0;
    logic [DATA_W-1:0] pattern_mask = '0;
    logic [DATA_W-1:0] mem_data = '0;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic              done_flag;
    logic [ADDR_W-1:0] match_address;
    logic              match_found;

    logic [DATA_W-1:0] ram [DEPTH];

    int n_checks = 0;
    int n_pass   = 0;

    pattern_compare #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clock         (clock),
        .reset         (reset),
        .inc_flag      (inc_flag),
        .pattern       (pattern),
        .pattern_mask  (pattern_mask),
        .mem_data      (mem_data),
        .mem_rd        (mem_rd),
        .mem_addr      (mem_addr),
        .done_flag     (done_flag),
        .match_address (match_address),
        .match_found   (match_found)
    );

    always #5 clock = ~clock;

    // Synchronous RAM, one cycle read latency.
    always @(posedge clock) if (mem_rd) mem_data <= ram[mem_addr];

    // Reference: index of first masked match, or -1.
    function automatic int ref_first(input logic [7:0] p, input logic [7:0] m);
        for (int i = 0; i < DEPTH; i++)
            if ((ram[i] & m) == (p & m)) return i;
        return -1;
    endfunction

    function automatic int ref_edge(input int k);
        return (k >= 0) ? k + 2 : DEPTH + 1;
    endfunction

    function automatic logic [ADDR_W-1:0] ref_addr(input int k);
        return (k >= 0) ? ADDR_W'(k) : {ADDR_W{1'b1}};
    endfunction

    task automatic fill_excluding(input logic [7:0] v);
        for (int i = 0; i < DEPTH; i++) begin
            ram[i] = 8'($urandom);
            if (ram[i] == v) ram[i] = v ^ 8'h01;
        end
    endtask

    // Starts a search (edge 0 is the first edge with inc_flag high), scrambles
    // the key inputs right after capture, and returns the edge index at which
    // done_flag was first seen (-1 if never). inc_flag stays high.
    task automatic do_search(input logic [7:0] p, input logic [7:0] m,
                             output int e_done);
        @(negedge clock);
        pattern = p; pattern_mask = m; inc_flag = 1'b1;
        e_done = -1;
        for (int e = 0; e < DEPTH + 8; e++) begin
            @(posedge clock); #1;
            if (e == 0) begin
                pattern = 8'($urandom); pattern_mask = 8'($urandom);
            end
            if (done_flag) begin
                e_done = e;
                break;
            end
        end
    endtask

    task automatic release_inc;
        @(negedge clock);
        inc_flag = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_reset;
        #1;
        n_checks++; if (mem_rd !== 1'b0) $display("FAIL reset_mem_rd: got %b want 0", mem_rd); else n_pass++;
        n_checks++; if (done_flag !== 1'b0) $display("FAIL reset_done: got %b want 0", done_flag); else n_pass++;
        n_checks++; if (match_found !== 1'b0) $display("FAIL reset_found: got %b want 0", match_found); else n_pass++;
        n_checks++; if (mem_addr !== '0) $display("FAIL reset_mem_addr: got %h want 0", mem_addr); else n_pass++;
        n_checks++; if (match_address !== '0) $display("FAIL reset_match_addr: got %h want 0", match_address); else n_pass++;
        @(negedge clock); reset = 1'b0;
    endtask

    task automatic test_basic_hit;
        int k, e;
        fill_excluding(8'hA5);
        ram[37] = 8'hA5;
        k = ref_first(8'hA5, 8'hFF);
        do_search(8'hA5, 8'hFF, e);
        n_checks++; if (e !== ref_edge(k)) $display("FAIL basic_edge: got %0d want %0d", e, ref_edge(k)); else n_pass++;
        n_checks++; if (match_address !== ref_addr(k)) $display("FAIL basic_addr: got %h want %h", match_address, ref_addr(k)); else n_pass++;
        n_checks++; if (match_found !== 1'b1) $display("FAIL basic_found: got %b want 1", match_found); else n_pass++;
        // Holding inc_flag high keeps the result and never restarts.
        repeat (6) @(posedge clock);
        #1;
        n_checks++; if (done_flag !== 1'b1 || mem_rd !== 1'b0) $display("FAIL hold_done: done=%b rd=%b want 1/0", done_flag, mem_rd); else n_pass++;
        release_inc;
        n_checks++; if (done_flag !== 1'b0) $display("FAIL release_done: got %b want 0", done_flag); else n_pass++;
        n_checks++; if (match_address !== ref_addr(k) || match_found !== 1'b1) $display("FAIL release_keep: addr=%h found=%b want %h/1", match_address, match_found, ref_addr(k)); else n_pass++;
    endtask

    task automatic test_first_hit;
        int k, e;
        fill_excluding(8'h3C);
        ram[5] = 8'h3C; ram[200] = 8'h3C;
        k = ref_first(8'h3C, 8'hFF);
        do_search(8'h3C, 8'hFF, e);
        n_checks++; if (e !== ref_edge(k)) $display("FAIL first_edge: got %0d want %0d", e, ref_edge(k)); else n_pass++;
        n_checks++; if (match_address !== ref_addr(k)) $display("FAIL first_addr: got %h want %h", match_address, ref_addr(k)); else n_pass++;
        n_checks++; if (mem_rd !== 1'b0) $display("FAIL first_mem_rd: got %b want 0", mem_rd); else n_pass++;
        release_inc;
    endtask

    task automatic test_full_miss;
        int k, e;
        fill_excluding(8'h77);
        k = ref_first(8'h77, 8'hFF);
        do_search(8'h77, 8'hFF, e);
        n_checks++; if (e !== ref_edge(k)) $display("FAIL miss_edge: got %0d want %0d", e, ref_edge(k)); else n_pass++;
        n_checks++; if (match_found !== 1'b0) $display("FAIL miss_found: got %b want 0", match_found); else n_pass++;
        n_checks++; if (match_address !== ref_addr(k)) $display("FAIL miss_addr: got %h want %h", match_address, ref_addr(k)); else n_pass++;
        n_checks++; if (mem_addr !== ADDR_W'(DEPTH - 1)) $display("FAIL miss_mem_addr: got %h want %h", mem_addr, ADDR_W'(DEPTH - 1)); else n_pass++;
        n_checks++; if (mem_rd !== 1'b0) $display("FAIL miss_mem_rd: got %b want 0", mem_rd); else n_pass++;
        release_inc;
    endtask

    task automatic test_masked_boundary;
        int k, e;
        for (int i = 0; i < DEPTH; i++) ram[i] = 8'h00;
        ram[DEPTH-1] = 8'hF3;
        k = ref_first(8'hF0, 8'hF0);
        do_search(8'hF0, 8'hF0, e);
        n_checks++; if (e !== ref_edge(k)) $display("FAIL bound_edge: got %0d want %0d", e, ref_edge(k)); else n_pass++;
        n_checks++; if (match_address !== ref_addr(k) || match_found !== 1'b1) $display("FAIL bound_result: addr=%h found=%b want %h/1", match_address, match_found, ref_addr(k)); else n_pass++;
        release_inc;
    endtask

    task automatic test_mask_zero;
        int k, e;
        fill_excluding(8'h00);
        k = ref_first(8'h5A, 8'h00);
        do_search(8'h5A, 8'h00, e);
        n_checks++; if (e !== ref_edge(k)) $display("FAIL mask0_edge: got %0d want %0d", e, ref_edge(k)); else n_pass++;
        n_checks++; if (match_address !== ref_addr(k) || match_found !== 1'b1) $display("FAIL mask0_result: addr=%h found=%b want %h/1", match_address, match_found, ref_addr(k)); else n_pass++;
        release_inc;
    endtask

    task automatic test_abort;
        int k, e;
        logic seen_done;
        fill_excluding(8'h99);
        ram[100] = 8'h99;
        @(negedge clock);
        pattern = 8'h99; pattern_mask = 8'hFF; inc_flag = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            if (done_flag) seen_done = 1'b1;
        end
        inc_flag = 1'b0;
        @(posedge clock); #1;
        if (done_flag) seen_done = 1'b1;
        n_checks++; if (seen_done !== 1'b0) $display("FAIL abort_done: got %b want 0", seen_done); else n_pass++;
        n_checks++; if (mem_rd !== 1'b0) $display("FAIL abort_mem_rd: got %b want 0", mem_rd); else n_pass++;
        n_checks++; if (match_found !== 1'b0 || match_address !== '0) $display("FAIL abort_result: found=%b addr=%h want 0/0", match_found, match_address); else n_pass++;
        // Restart on the very next edge.
        ram[3] = 8'hC7;
        k = ref_first(8'hC7, 8'hFF);
        do_search(8'hC7, 8'hFF, e);
        n_checks++; if (e !== ref_edge(k)) $display("FAIL restart_edge: got %0d want %0d", e, ref_edge(k)); else n_pass++;
        n_checks++; if (match_address !== ref_addr(k) || match_found !== 1'b1) $display("FAIL restart_result: addr=%h found=%b want %h/1", match_address, match_found, ref_addr(k)); else n_pass++;
        release_inc;
    endtask

    task automatic test_reset_mid_scan;
        logic idle_ok;
        fill_excluding(8'h42);
        @(negedge clock);
        pattern = 8'h42; pattern_mask = 8'hFF; inc_flag = 1'b1;
        repeat (30) @(posedge clock);
        #3 reset = 1'b1;
        #1;
        n_checks++; if (mem_rd !== 1'b0 || done_flag !== 1'b0) $display("FAIL midrst_ctrl: rd=%b done=%b want 0/0", mem_rd, done_flag); else n_pass++;
        n_checks++; if (mem_addr !== '0) $display("FAIL midrst_mem_addr: got %h want 0", mem_addr); else n_pass++;
        n_checks++; if (match_found !== 1'b0 || match_address !== '0) $display("FAIL midrst_result: found=%b addr=%h want 0/0", match_found, match_address); else n_pass++;
        inc_flag = 1'b0;
        @(negedge clock); reset = 1'b0;
        idle_ok = 1'b1;
        repeat (10) begin
            @(posedge clock); #1;
            if (mem_rd || done_flag || mem_addr != '0) idle_ok = 1'b0;
        end
        n_checks++; if (idle_ok !== 1'b1) $display("FAIL midrst_idle: got %b want 1", idle_ok); else n_pass++;
    endtask

    task automatic test_random;
        int k, e;
        logic [7:0] p, m;
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < DEPTH; i++) ram[i] = 8'($urandom);
            p = (it % 2 == 0) ? ram[$urandom_range(DEPTH-1, 0)] : 8'($urandom);
            m = (it % 3 == 0) ? 8'hFF : 8'($urandom);
            k = ref_first(p, m);
            do_search(p, m, e);
            n_checks++; if (e !== ref_edge(k)) $display("FAIL rand%0d_edge: got %0d want %0d", it, e, ref_edge(k)); else n_pass++;
            n_checks++; if (match_address !== ref_addr(k) || match_found !== (k >= 0)) $display("FAIL rand%0d_result: addr=%h found=%b want %h/%b", it, match_address, match_found, ref_addr(k), (k >= 0)); else n_pass++;
            release_inc;
        end
    endtask

    initial begin
        test_reset;
        test_basic_hit;
        test_first_hit;
        test_full_miss;
        test_masked_boundary;
        test_mask_zero;
        test_abort;
        test_reset_mid_scan;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
